seq_or_and_tracker: RTL

// - Hardware evaluator for two concurrent-sequence properties. Both share one trigger, $rose(a).
// - OR property: ($rose(a) ##[B_MIN:B_MAX] b) or ($rose(a) ##[C_MIN:C_MAX] c).
// - AND property: the same two sequences combined with and.
// - Each $rose(a) is an independent attempt in one of NTHREADS thread slots.
// - Per-thread pass/fail pulses let the bench compare against the simulator's assertion results.

---
 rtl/seq_or_and_tracker_if.sv | 34 +++
 rtl/seq_or_and_tracker.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_or_and_tracker_if.sv
// ---------------------------------------------------------------------------
// seq_or_and_tracker_if
// Purpose : bundles the trigger/consequent inputs and the per-slot result
//           vectors of seq_or_and_tracker.
// Signals : a, b, c                 - trigger and the two sequence consequents
//           or_pass/or_fail         - per-slot OR property result pulses
//           and_pass/and_fail       - per-slot AND property result pulses
//           busy                    - per-slot occupied flags
//           drop                    - trigger arrived with every slot taken
// Modports: master drives a/b/c (stimulus side), slave is the tracker.
// ---------------------------------------------------------------------------
interface seq_or_and_tracker_if #(
    parameter int NTHREADS = 4
);
    logic                a;
    logic                b;
    logic                c;
    logic [NTHREADS-1:0] or_pass;
    logic [NTHREADS-1:0] or_fail;
    logic [NTHREADS-1:0] and_pass;
    logic [NTHREADS-1:0] and_fail;
    logic [NTHREADS-1:0] busy;
    logic                drop;

    modport master (
        output a, b, c,
        input  or_pass, or_fail, and_pass, and_fail, busy, drop
    );

    modport slave (
        input  a, b, c,
        output or_pass, or_fail, and_pass, and_fail, busy, drop
    );
endinterface

// File: rtl/seq_or_and_tracker.sv
// ---------------------------------------------------------------------------
// seq_or_and_tracker
// Purpose : evaluates, for every $rose(a), the two properties
//             OR : (a ##[B_MIN:B_MAX] b) or  (a ##[C_MIN:C_MAX] c)
//             AND: (a ##[B_MIN:B_MAX] b) and (a ##[C_MIN:C_MAX] c)
//           Each rise of a occupies one of NTHREADS slots until both
//           properties have resolved; results are 1-cycle pulses per slot.
// Ports   : clk      - clock, all logic on posedge
//           rst      - synchronous active-high reset
//           bus      - seq_or_and_tracker_if.slave (a/b/c in, results out)
//           or_pass_cnt, or_fail_cnt, and_pass_cnt, and_fail_cnt, drop_cnt
//                    - 16-bit saturating event counters, present only when
//                      SEQ_TRACKER_STATS_EN is defined
// Config  : SEQ_TRACKER_STATS_EN adds the statistics counters; pass/fail
//           behaviour is identical either way.
// ---------------------------------------------------------------------------

// One attempt slot. cnt_q holds the age of the attempt in the current cycle
// (trigger cycle = 0), so it is loaded with 1 when the slot is allocated.
module seq_tracker_slot #(
    parameter int B_MIN = 1,
    parameter int B_MAX = 5,
    parameter int C_MIN = 1,
    parameter int C_MAX = 2,
    parameter int CW    = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic alloc_i,
    input  logic b_i,
    input  logic c_i,
    output logic free_o,
    output logic busy_o,
    output logic or_pass_o,
    output logic or_fail_o,
    output logic and_pass_o,
    output logic and_fail_o
);
    localparam int MAX_BC = (B_MAX > C_MAX) ? B_MAX : C_MAX;

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          b_hit_q, c_hit_q;
    logic          or_done_q, and_done_q;
    logic          freed_q;
    logic          or_pass_q, or_fail_q, and_pass_q, and_fail_q;

    int   age;
    logic active;
    logic b_eff, c_eff;
    logic or_pass_d, or_fail_d, and_pass_d, and_fail_d;

    always_comb begin
        age    = int'(cnt_q);
        active = (state_q == S_ACTIVE);
        // Sticky hit or a hit sampled this cycle inside its window.
        b_eff  = b_hit_q | (b_i & (age >= B_MIN) & (age <= B_MAX));
        c_eff  = c_hit_q | (c_i & (age >= C_MIN) & (age <= C_MAX));

        or_pass_d  = active & ~or_done_q & (b_eff | c_eff);
        // OR gives up only in the first cycle beyond both windows.
        or_fail_d  = active & ~or_done_q & ~(b_eff | c_eff) & (age > MAX_BC);

        and_pass_d = active & ~and_done_q & b_eff & c_eff;
        // AND fails as soon as the last sample of either window misses.
        and_fail_d = active & ~and_done_q & ~(b_eff & c_eff) &
                     (((age >= B_MAX) & ~b_eff) | ((age >= C_MAX) & ~c_eff));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            b_hit_q    <= 1'b0;
            c_hit_q    <= 1'b0;
            or_done_q  <= 1'b0;
            and_done_q <= 1'b0;
            freed_q    <= 1'b0;
            or_pass_q  <= 1'b0;
            or_fail_q  <= 1'b0;
            and_pass_q <= 1'b0;
            and_fail_q <= 1'b0;
        end else begin
            or_pass_q  <= or_pass_d;
            or_fail_q  <= or_fail_d;
            and_pass_q <= and_pass_d;
            and_fail_q <= and_fail_d;
            freed_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (alloc_i) begin
                        state_q    <= S_ACTIVE;
                        cnt_q      <= CW'(1);
                        b_hit_q    <= 1'b0;
                        c_hit_q    <= 1'b0;
                        or_done_q  <= 1'b0;
                        and_done_q <= 1'b0;
                    end
                end
                S_ACTIVE: begin
                    if (or_done_q && and_done_q) begin
                        // freed_q keeps the slot out of allocation for one
                        // more cycle after busy drops.
                        state_q <= S_IDLE;
                        freed_q <= 1'b1;
                    end else begin
                        cnt_q      <= (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                        b_hit_q    <= b_eff;
                        c_hit_q    <= c_eff;
                        or_done_q  <= or_done_q  | or_pass_d  | or_fail_d;
                        and_done_q <= and_done_q | and_pass_d | and_fail_d;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign free_o     = (state_q == S_IDLE) & ~freed_q;
    assign busy_o     = (state_q == S_ACTIVE);
    assign or_pass_o  = or_pass_q;
    assign or_fail_o  = or_fail_q;
    assign and_pass_o = and_pass_q;
    assign and_fail_o = and_fail_q;
endmodule

module seq_or_and_tracker #(
    parameter int NTHREADS = 4,
    parameter int B_MIN    = 1,
    parameter int B_MAX    = 5,
    parameter int C_MIN    = 1,
    parameter int C_MAX    = 2,
    parameter int CW       = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_or_and_tracker_if.slave  bus
`ifdef SEQ_TRACKER_STATS_EN
    ,
    output logic [15:0]          or_pass_cnt,
    output logic [15:0]          or_fail_cnt,
    output logic [15:0]          and_pass_cnt,
    output logic [15:0]          and_fail_cnt,
    output logic [15:0]          drop_cnt
`endif
);
    logic                a_q;
    logic                drop_q;
    logic                rise;
    logic                found;
    logic [NTHREADS-1:0] free, alloc;
    logic [NTHREADS-1:0] busy, or_pass, or_fail, and_pass, and_fail;

    assign rise = bus.a & ~a_q;

    // Lowest-index free slot takes the new attempt.
    always_comb begin
        alloc = '0;
        found = 1'b0;
        for (int i = 0; i < NTHREADS; i++) begin
            if (rise && free[i] && !found) begin
                alloc[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            a_q    <= bus.a;
            drop_q <= rise & ~(|free);
        end
    end

    for (genvar g = 0; g < NTHREADS; g++) begin : g_slot
        seq_tracker_slot #(
            .B_MIN(B_MIN), .B_MAX(B_MAX), .C_MIN(C_MIN), .C_MAX(C_MAX), .CW(CW)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .alloc_i   (alloc[g]),
            .b_i       (bus.b),
            .c_i       (bus.c),
            .free_o    (free[g]),
            .busy_o    (busy[g]),
            .or_pass_o (or_pass[g]),
            .or_fail_o (or_fail[g]),
            .and_pass_o(and_pass[g]),
            .and_fail_o(and_fail[g])
        );
    end

    assign bus.busy     = busy;
    assign bus.or_pass  = or_pass;
    assign bus.or_fail  = or_fail;
    assign bus.and_pass = and_pass;
    assign bus.and_fail = and_fail;
    assign bus.drop     = drop_q;

`ifdef SEQ_TRACKER_STATS_EN
    function automatic logic [3:0] popcnt(input logic [NTHREADS-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < NTHREADS; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] acc, input logic [3:0] inc);
        logic [16:0] s;
        s = {1'b0, acc} + {13'b0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    logic [15:0] or_pass_cnt_q, or_fail_cnt_q, and_pass_cnt_q, and_fail_cnt_q, drop_cnt_q;

    // Counters accumulate the pulses as they appear on the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            or_pass_cnt_q  <= '0;
            or_fail_cnt_q  <= '0;
            and_pass_cnt_q <= '0;
            and_fail_cnt_q <= '0;
            drop_cnt_q     <= '0;
        end else begin
            or_pass_cnt_q  <= sat_add(or_pass_cnt_q,  popcnt(or_pass));
            or_fail_cnt_q  <= sat_add(or_fail_cnt_q,  popcnt(or_fail));
            and_pass_cnt_q <= sat_add(and_pass_cnt_q, popcnt(and_pass));
            and_fail_cnt_q <= sat_add(and_fail_cnt_q, popcnt(and_fail));
            drop_cnt_q     <= sat_add(drop_cnt_q,     {3'b000, drop_q});
        end
    end

    assign or_pass_cnt  = or_pass_cnt_q;
    assign or_fail_cnt  = or_fail_cnt_q;
    assign and_pass_cnt = and_pass_cnt_q;
    assign and_fail_cnt = and_fail_cnt_q;
    assign drop_cnt     = drop_cnt_q;
`endif
endmodule
